// File: rtl/slotmaker_sequencer_pkg.sv
// Shared types and helpers for the slotmaker configuration sequencer.
package slot_cfg_pkg;

  localparam int NUM_SLOTS_MAX = 8;

  typedef logic [7:0] card_id_t;

  typedef enum logic [2:0] {
    START,
    LOAD,
    HOSTWR,
    RECONFIG,
    IDLE
  } slot_seq_state_t;

  // Slot s occupies byte s of a packed card map.
  function automatic card_id_t map_card(input logic [8*NUM_SLOTS_MAX-1:0] map, input int s);
    return map[8*s +: 8];
  endfunction

endpackage

// File: rtl/slotmaker_sequencer_if.sv
// Host request path plus the slotmaker configuration port, as seen by the sequencer.
interface slotmaker_sequencer_if;
  import slot_cfg_pkg::*;

  logic     req_i;
  logic [2:0] req_slot_i;
  card_id_t req_card_i;
  logic     ack_o;
  logic [2:0] cfg_slot_o;
  logic     cfg_wr_o;
  card_id_t cfg_card_o;
  logic     cfg_reconfig_o;
  logic     busy_o;

  modport slave (
    input  req_i, req_slot_i, req_card_i,
    output ack_o, cfg_slot_o, cfg_wr_o, cfg_card_o, cfg_reconfig_o, busy_o
  );

  modport master (
    output req_i, req_slot_i, req_card_i,
    input  ack_o, cfg_slot_o, cfg_wr_o, cfg_card_o, cfg_reconfig_o, busy_o
  );
endinterface

// File: rtl/slotmaker_sequencer_stable_detect.sv
// Debounce: flags a change once sample differs from reference for SETTLE_CYCLES samples in a row.
module stable_detect #(
  parameter int SETTLE_CYCLES = 54_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic reference_i,
  input  logic clear_i,
  output logic changed_o
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          changed_q, changed_d;

  always_comb begin
    cnt_d     = '0;
    changed_d = changed_q;
    if (sample_i != reference_i) begin
      cnt_d = (cnt_q == CW'(SETTLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q == CW'(SETTLE_CYCLES - 1)) changed_d = 1'b1;
    end
    // Clearing coincides with the reference taking the new value, so it wins.
    if (clear_i) changed_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  assign changed_o = changed_q;
endmodule

// File: rtl/slotmaker_sequencer.sv
// Loads the slot/card table into slotmaker after reset and on switch changes,
// and grants single-slot host overrides between sweeps.
module slotmaker_sequencer
  import slot_cfg_pkg::*;
#(
  parameter int          NUM_SLOTS     = 8,
  parameter logic [63:0] SLOT_MAP      = 64'h0000_0000_0302_0100,
  parameter logic [63:0] ALT_MAP       = 64'h0300_0000_0002_0100,
  parameter int          SETTLE_CYCLES = 54_000
) (
  input  logic                  clk_logic,
  input  logic                  device_reset_n,
  input  logic                  slot_sel_n_i,
  slotmaker_sequencer_if.slave  bus
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  slot_seq_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  card_id_t [NUM_SLOTS-1:0] shadow_q, shadow_d;
  logic applied_sel_q, applied_sel_d;
  logic change_pending, change_clear;

  logic       wr_q, wr_d, rc_q, rc_d, ack_q, ack_d, busy_q, busy_d;
  logic [2:0] slot_q, slot_d;
  card_id_t   card_q, card_d;

  stable_detect #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_sel_detect (
    .clk         (clk_logic),
    .rst_n       (device_reset_n),
    .sample_i    (!slot_sel_n_i),
    .reference_i (applied_sel_q),
    .clear_i     (change_clear),
    .changed_o   (change_pending)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    applied_sel_d = applied_sel_q;
    change_clear  = 1'b0;
    wr_d   = 1'b0;
    rc_d   = 1'b0;
    ack_d  = 1'b0;
    busy_d = 1'b0;
    slot_d = '0;
    card_d = '0;
    unique case (state_q)
      START: begin
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        wr_d   = 1'b1;
        busy_d = 1'b1;
        slot_d = 3'(idx_q);
        card_d = shadow_q[idx_q];
        idx_d  = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = RECONFIG;
      end
      HOSTWR: begin
        wr_d   = 1'b1;
        ack_d  = 1'b1;
        busy_d = 1'b1;
        slot_d = bus.req_slot_i;
        card_d = bus.req_card_i;
        // Out-of-range slots still reach the port but leave the table alone.
        for (int s = 0; s < NUM_SLOTS; s++)
          if (bus.req_slot_i == 3'(s)) shadow_d[s] = bus.req_card_i;
        state_d = RECONFIG;
      end
      RECONFIG: begin
        rc_d    = 1'b1;
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        if (change_pending) begin
          for (int s = 0; s < NUM_SLOTS; s++)
            shadow_d[s] = applied_sel_q ? map_card(SLOT_MAP, s) : map_card(ALT_MAP, s);
          applied_sel_d = !applied_sel_q;
          change_clear  = 1'b1;
          idx_d         = '0;
          state_d       = LOAD;
        end else if (bus.req_i) begin
          state_d = HOSTWR;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state_q       <= START;
      idx_q         <= '0;
      applied_sel_q <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) shadow_q[s] <= map_card(SLOT_MAP, s);
      wr_q   <= 1'b0;
      rc_q   <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      slot_q <= '0;
      card_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      applied_sel_q <= applied_sel_d;
      shadow_q      <= shadow_d;
      wr_q   <= wr_d;
      rc_q   <= rc_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      slot_q <= slot_d;
      card_q <= card_d;
    end
  end

  assign bus.cfg_wr_o       = wr_q;
  assign bus.cfg_reconfig_o = rc_q;
  assign bus.ack_o          = ack_q;
  assign bus.busy_o         = busy_q;
  assign bus.cfg_slot_o     = slot_q;
  assign bus.cfg_card_o     = card_q;
endmodule

// File: tb/tb_slotmaker_sequencer.sv
// Scenario bench for slotmaker_sequencer: expected port events are queued and matched as they appear.
module tb_slotmaker_sequencer;
  import slot_cfg_pkg::*;

  localparam int          NS   = 8;
  localparam int          SC   = 16;
  localparam logic [63:0] SMAP = 64'h0000_0000_0302_0100;
  localparam logic [63:0] AMAP = 64'h0300_0000_0002_0100;

  typedef struct packed {
    logic       rc;
    logic       ack;
    logic [2:0] slot;
    logic [7:0] card;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  ev_t  q[$];
  ev_t  e;
  bit   ev_ok;

  slotmaker_sequencer_if bus();

  slotmaker_sequencer #(
    .NUM_SLOTS(NS), .SLOT_MAP(SMAP), .ALT_MAP(AMAP), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_logic      (clk),
    .device_reset_n (rst_n),
    .slot_sel_n_i   (sel_n),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe on the port must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (bus.cfg_wr_o || bus.cfg_reconfig_o || bus.ack_o)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got wr=%b rc=%b ack=%b slot=%0d card=%h", bus.cfg_wr_o,
                 bus.cfg_reconfig_o, bus.ack_o, bus.cfg_slot_o, bus.cfg_card_o);
      end else begin
        e = q.pop_front();
        if (e.rc) ev_ok = bus.cfg_reconfig_o && !bus.cfg_wr_o && !bus.ack_o;
        else ev_ok = !bus.cfg_reconfig_o && bus.cfg_wr_o && (bus.ack_o === e.ack) &&
                     (bus.cfg_slot_o === e.slot) && (bus.cfg_card_o === e.card);
        if (!ev_ok) begin
          errors++;
          $display("FAIL sb_event got wr=%b rc=%b ack=%b slot=%0d card=%h exp rc=%b ack=%b slot=%0d card=%h",
                   bus.cfg_wr_o, bus.cfg_reconfig_o, bus.ack_o, bus.cfg_slot_o, bus.cfg_card_o,
                   e.rc, e.ack, e.slot, e.card);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_sweep(input logic [63:0] m);
    ev_t x;
    for (int s = 0; s < NS; s++) begin
      x = '{rc: 1'b0, ack: 1'b0, slot: 3'(s), card: m[8*s +: 8]};
      q.push_back(x);
    end
    x = '{rc: 1'b1, ack: 1'b0, slot: 3'd0, card: 8'h00};
    q.push_back(x);
  endtask

  task automatic push_host(input logic [2:0] slot, input logic [7:0] card);
    ev_t x;
    x = '{rc: 1'b0, ack: 1'b1, slot: slot, card: card};
    q.push_back(x);
    x = '{rc: 1'b1, ack: 1'b0, slot: 3'd0, card: 8'h00};
    q.push_back(x);
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic bz[12];
    logic wr2, rc10;
    logic [2:0] slot2;
    bit ok;
    rst_n = 1'b0; sel_n = 1'b1;
    bus.req_i = 1'b0; bus.req_slot_i = '0; bus.req_card_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.cfg_wr_o, bus.cfg_reconfig_o, bus.ack_o, bus.busy_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 0000",
               {bus.cfg_wr_o, bus.cfg_reconfig_o, bus.ack_o, bus.busy_o});
    end
    checks++;
    if (bus.cfg_slot_o !== 3'd0 || bus.cfg_card_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus got slot=%0d card=%h want 0/00", bus.cfg_slot_o, bus.cfg_card_o);
    end
    push_sweep(SMAP);
    @(negedge clk);
    rst_n = 1'b1;
    wr2 = 1'b0; rc10 = 1'b0; slot2 = 3'd7;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      bz[k] = bus.busy_o;
      if (k == 2) begin wr2 = bus.cfg_wr_o; slot2 = bus.cfg_slot_o; end
      if (k == 10) rc10 = bus.cfg_reconfig_o;
    end
    checks++;
    if (bz[1] !== 1'b0 || bz[2] !== 1'b1 || bz[10] !== 1'b1 || bz[11] !== 1'b0) begin
      errors++;
      $display("FAIL boot_busy got e1=%b e2=%b e10=%b e11=%b want 0 1 1 0", bz[1], bz[2], bz[10], bz[11]);
    end
    checks++;
    if (wr2 !== 1'b1 || slot2 !== 3'd0) begin
      errors++;
      $display("FAIL boot_first_write got wr=%b slot=%0d at edge 2 want 1/0", wr2, slot2);
    end
    checks++;
    if (rc10 !== 1'b1) begin
      errors++;
      $display("FAIL boot_reconfig got %b at edge 10 want 1", rc10);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL boot_drain left=%0d want 0", q.size()); end
  endtask

  task automatic test_switch_short;
    logic busy_seen;
    @(posedge clk);
    #1 sel_n = 1'b0;
    repeat (SC - 1) @(posedge clk);
    #1 sel_n = 1'b1;
    busy_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy_o;
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL switch_short got busy=%b want 0", busy_seen);
    end
  endtask

  task automatic test_switch_sweep;
    bit ok;
    push_sweep(AMAP);
    @(posedge clk);
    #1 sel_n = 1'b0;
    repeat (SC) @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_wr_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL settle_early got wr=%b busy=%b want 0/0", bus.cfg_wr_o, bus.busy_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_wr_o !== 1'b1 || bus.cfg_slot_o !== 3'd0 || bus.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL settle_start got wr=%b slot=%0d busy=%b want 1/0/1",
               bus.cfg_wr_o, bus.cfg_slot_o, bus.busy_o);
    end
    wait_drain(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL alt_sweep_drain left=%0d want 0", q.size()); end
  endtask

  task automatic test_host_write;
    bit ok;
    bit got;
    got = 1'b0;
    push_host(3'd4, 8'h05);
    @(posedge clk);
    #1;
    bus.req_i = 1'b1; bus.req_slot_i = 3'd4; bus.req_card_i = 8'h05;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) begin got = 1'b1; break; end
    end
    checks++;
    if (!got || bus.cfg_wr_o !== 1'b1 || bus.cfg_slot_o !== 3'd4 || bus.cfg_card_o !== 8'h05) begin
      errors++;
      $display("FAIL host_ack got ack=%b wr=%b slot=%0d card=%h want 1/1/4/05",
               got, bus.cfg_wr_o, bus.cfg_slot_o, bus.cfg_card_o);
    end
    bus.req_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cfg_reconfig_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.ack_o !== 1'b0) begin
      errors++;
      $display("FAIL host_reconfig got rc=%b busy=%b ack=%b want 1/1/0",
               bus.cfg_reconfig_o, bus.busy_o, bus.ack_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL host_busy_end got %b want 0", bus.busy_o); end
    push_sweep(SMAP);
    sel_n = 1'b1;
    wait_drain(SC + 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL override_discard_drain left=%0d want 0", q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok, got, fell;
    int n;
    @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    push_sweep(SMAP);
    push_host(3'd2, 8'hAA);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.req_i = 1'b1; bus.req_slot_i = 3'd2; bus.req_card_i = 8'hAA;
    got = 1'b0; fell = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) begin got = 1'b1; break; end
      if (!bus.busy_o) fell = 1'b1;
    end
    checks++;
    if (!got || !fell) begin
      errors++;
      $display("FAIL wait_while_busy got ack=%b busy_fell_first=%b want 1/1", got, fell);
    end
    bus.req_i = 1'b0;
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL boot_req_drain left=%0d want 0", q.size()); end
    // Switch settles on the same edge the request appears: sweep must win.
    push_sweep(AMAP);
    push_host(3'd6, 8'h5C);
    @(posedge clk);
    #1 sel_n = 1'b0;
    repeat (SC) @(posedge clk);
    #1;
    bus.req_i = 1'b1; bus.req_slot_i = 3'd6; bus.req_card_i = 8'h5C;
    got = 1'b0; n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o) begin got = 1'b1; n = k; break; end
    end
    bus.req_i = 1'b0;
    checks++;
    if (!got || n != NS + 4) begin
      errors++;
      $display("FAIL sweep_before_req got ack=%b after %0d cycles want 1 after %0d", got, n, NS + 4);
    end
    wait_drain(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL arb_drain left=%0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid_sweep;
    bit ok, found;
    push_sweep(SMAP);
    @(posedge clk);
    #1 sel_n = 1'b1;
    wait_drain(SC + 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pre_sweep_drain left=%0d want 0", q.size()); end
    push_sweep(AMAP);
    @(posedge clk);
    #1 sel_n = 1'b0;
    found = 1'b0;
    for (int k = 0; k < SC + 30; k++) begin
      @(negedge clk);
      if (bus.cfg_wr_o && bus.cfg_slot_o == 3'd5) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_slot5 got none want write to slot 5"); end
    #2;
    rst_n = 1'b0;
    sel_n = 1'b1;
    #1;
    checks++;
    if ({bus.cfg_wr_o, bus.cfg_reconfig_o, bus.ack_o, bus.busy_o} !== 4'b0 ||
        bus.cfg_slot_o !== 3'd0 || bus.cfg_card_o !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got wr=%b rc=%b ack=%b busy=%b slot=%0d card=%h want all 0",
               bus.cfg_wr_o, bus.cfg_reconfig_o, bus.ack_o, bus.busy_o, bus.cfg_slot_o, bus.cfg_card_o);
    end
    q.delete();
    push_sweep(SMAP);
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reboot_drain left=%0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_switch_short();
    test_switch_sweep();
    test_host_write();
    test_back_to_back();
    test_reset_mid_sweep();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
